// File: rtl/led_fader.sv
// LED brightness fader: walks threshold one level at a time toward a requested
// target at a programmable step rate, then pulses done.
module led_fader #(
  parameter int unsigned MAX_LEVEL = 246,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           target,
  input  logic                 target_valid,
  output logic                 target_ready,
  input  logic [DIV_WIDTH-1:0] step_div,
  output logic [7:0]           threshold,
  output logic                 busy,
  output logic                 done
);

  localparam logic [7:0] MAX_L = 8'(MAX_LEVEL);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t               state;
  state_t               state_next;
  logic [DIV_WIDTH-1:0] prescaler;
  logic [DIV_WIDTH-1:0] div_q;
  logic [7:0]           tgt_q;

  logic [7:0] clamped_c;
  logic [7:0] thr_inc_c;
  logic [7:0] thr_dec_c;
  logic       accept_c;
  logic       step_c;
  logic       arrive_c;

  assign clamped_c = (target > MAX_L) ? MAX_L : target;
  assign thr_inc_c = threshold + 8'd1;
  assign thr_dec_c = threshold - 8'd1;
  assign accept_c  = target_valid && (state == IDLE);
  assign step_c    = (prescaler == div_q);
  // Arrival is decided on the step edge that lands exactly on the latched target.
  assign arrive_c  = step_c &&
                     (((state == RAMP_UP)   && (thr_inc_c == tgt_q)) ||
                      ((state == RAMP_DOWN) && (thr_dec_c == tgt_q)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (clamped_c > threshold) begin
            state_next = RAMP_UP;
          end else if (clamped_c < threshold) begin
            state_next = RAMP_DOWN;
          end
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (arrive_c) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    target_ready = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE:               target_ready = 1'b1;
      RAMP_UP, RAMP_DOWN: busy         = 1'b1;
      default:            target_ready = 1'b0;
    endcase
  end

  // Datapath: request latch, step prescaler, level and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      threshold <= 8'd0;
      prescaler <= '0;
      div_q     <= '0;
      tgt_q     <= 8'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            tgt_q     <= clamped_c;
            div_q     <= step_div;
            prescaler <= '0;
            if (clamped_c == threshold) begin
              done <= 1'b1;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (step_c) begin
            prescaler <= '0;
            threshold <= (state == RAMP_UP) ? thr_inc_c : thr_dec_c;
            done      <= arrive_c;
          end else begin
            prescaler <= prescaler + DIV_WIDTH'(1);
          end
        end
        default: prescaler <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: each request queues its per-cycle expected
// outputs from a reference fade model, which are popped and checked edge by edge.
module tb_led_fader;

  localparam int MAX_LEVEL = 246;

  typedef struct packed {
    logic [7:0] thr;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  target;
  logic        target_valid;
  logic        target_ready;
  logic [15:0] step_div;
  logic [7:0]  threshold;
  logic        busy;
  logic        done;

  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;
  int   model_thr;

  led_fader #(.MAX_LEVEL(246), .DIV_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .step_div     (step_div),
    .threshold    (threshold),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " threshold"}, 32'(threshold), 32'(e.thr));
    chk({tag, " busy"},      32'(busy),      32'(e.busy));
    chk({tag, " done"},      32'(done),      32'(e.done));
    chk({tag, " ready"},     32'(target_ready), 32'(e.ready));
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    reset        = 1'b1;
    target_valid = 1'b1;
    target       = 8'd100;
    step_div     = 16'd0;
    tick();
    tick();
    e = '{thr: 8'd0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    chk_all(tag, e);
    reset        = 1'b0;
    target_valid = 1'b0;
    model_thr    = 0;
    exp_q.delete();
  endtask

  // early: stop after the done cycle so the caller can accept in that cycle.
  // pulse_k: drive an ignored target=0 request after cycle k. abort_k: stop after cycle k.
  task automatic fade(input string tag, input int tgt, input int div, input bit early,
                      input int pulse_k, input int abort_k);
    int   clamp, delta, mag, total, last, s;
    exp_t e;
    clamp = (tgt > MAX_LEVEL) ? MAX_LEVEL : tgt;
    delta = clamp - model_thr;
    mag   = (delta < 0) ? -delta : delta;
    total = mag * (div + 1);
    last  = early ? total : total + 1;
    if (abort_k >= 0) last = abort_k;
    for (int k = 0; k <= last; k++) begin
      s = k / (div + 1);
      if (s > mag) s = mag;
      e.thr   = 8'((delta >= 0) ? model_thr + s : model_thr - s);
      e.busy  = (k < total);
      e.done  = (k == total);
      e.ready = !(k < total);
      exp_q.push_back(e);
    end
    target       = 8'(tgt);
    step_div     = 16'(div);
    target_valid = 1'b1;
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      tick();
      target_valid = 1'b0;
      chk_all($sformatf("%s k%0d", tag, k), e);
      if (k == pulse_k) begin
        target       = 8'd0;
        target_valid = 1'b1;
      end
    end
    model_thr = int'(e.thr);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_thr    = 0;
    reset        = 1'b0;
    target       = 8'd0;
    target_valid = 1'b0;
    step_div     = 16'd0;

    do_reset("reset_init");
    fade("up4_div0", 4, 0, 1'b0, -1, -1);

    do_reset("reset_b");
    fade("up10_div2", 10, 2, 1'b1, -1, -1);
    fade("up255_clamp", 255, 0, 1'b0, -1, -1);
    fade("down0", 0, 0, 1'b0, -1, -1);
    fade("up200_pulse", 200, 1, 1'b0, 20, -1);

    do_reset("reset_c");
    fade("up100_abort", 100, 0, 1'b0, -1, 50);
    chk("abort_point threshold", 32'(threshold), 32'd50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("abort_reset", '{thr: 8'd0, busy: 1'b0, done: 1'b0, ready: 1'b1});
    tick();
    chk_all("abort_after", '{thr: 8'd0, busy: 1'b0, done: 1'b0, ready: 1'b1});
    model_thr = 0;
    fade("equal0", 0, 3, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
